carrier_nco_gen: RTL and testbench

//  Carrier NCO for one correlator channel. A phase accumulator drives a 3-bit

---
 rtl/carrier_pkg.sv | 33 +++
 rtl/carrier_lut.sv | 24 ++
 rtl/carrier_nco_gen.sv | 105 ++++++++++
 tb/tb_carrier_nco_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/carrier_pkg.sv
// Shared definitions for the carrier NCO: default widths and the sector
// lookup table in the 2-bit {sign, mag} mixer format
// (sign 1 = positive, mag 1 = |2|, mag 0 = |1|).
package carrier_pkg;

  localparam int unsigned PHASE_W_DEF = 30;
  localparam int unsigned CYCLE_W_DEF = 20;
  localparam int unsigned VAL_W_DEF   = 10;

  localparam logic [1:0] SM_POS1 = 2'b10;
  localparam logic [1:0] SM_POS2 = 2'b11;
  localparam logic [1:0] SM_NEG1 = 2'b00;
  localparam logic [1:0] SM_NEG2 = 2'b01;

  // One carrier sample pair: I (cos) and Q (sin) in {sign, mag} form
  typedef struct packed {
    logic [1:0] i_sm;
    logic [1:0] q_sm;
  } iq_sm_t;

  // Sector 7 down to sector 0; each sector spans 45 degrees of phase
  localparam iq_sm_t [7:0] SECTOR_TABLE = {
    {SM_POS2, SM_NEG1},  // 7
    {SM_POS1, SM_NEG2},  // 6
    {SM_NEG1, SM_NEG2},  // 5
    {SM_NEG2, SM_NEG1},  // 4
    {SM_NEG2, SM_POS1},  // 3
    {SM_NEG1, SM_POS2},  // 2
    {SM_POS1, SM_POS2},  // 1
    {SM_POS2, SM_POS1}   // 0
  };

endpackage

// File: rtl/carrier_lut.sv
// Combinational sector decode: 3-bit phase sector -> I/Q carrier samples.
// Ports:
//   sector_i  3-bit phase sector (accumulator MSBs)
//   i_sign_o, i_mag_o  in-phase sample
//   q_sign_o, q_mag_o  quadrature sample
module carrier_lut
  import carrier_pkg::*;
(
  input  logic [2:0] sector_i,
  output logic       i_sign_o,
  output logic       i_mag_o,
  output logic       q_sign_o,
  output logic       q_mag_o
);

  iq_sm_t entry;

  assign entry    = SECTOR_TABLE[sector_i];
  assign i_sign_o = entry.i_sm[1];
  assign i_mag_o  = entry.i_sm[0];
  assign q_sign_o = entry.q_sm[1];
  assign q_mag_o  = entry.q_sm[0];

endmodule

// File: rtl/carrier_nco_gen.sv
// Carrier NCO for one correlator channel: phase accumulator, sector-based
// I/Q carrier samples, whole-cycle counter, and phase/cycle latches on tic.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   enable                    sample strobe; accumulator advances when high
//   f_control_wr, f_control   load phase increment
//   phase_wr, phase_in        preset accumulator (overrides accumulation)
//   tic                       measurement strobe: latch phase and cycle count
//   i_sign, i_mag             in-phase carrier sample (decoded from acc)
//   q_sign, q_mag             quadrature carrier sample (decoded from acc)
//   carrier_val               accumulator MSBs latched at tic
//   cycle_count               carrier cycles since the previous tic
module carrier_nco_gen
  import carrier_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned CYCLE_W = CYCLE_W_DEF,
  parameter int unsigned VAL_W   = VAL_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               f_control_wr,
  input  logic [PHASE_W-1:0] f_control,
  input  logic               phase_wr,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               tic,
  output logic               i_sign,
  output logic               i_mag,
  output logic               q_sign,
  output logic               q_mag,
  output logic [VAL_W-1:0]   carrier_val,
  output logic [CYCLE_W-1:0] cycle_count
);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] freq_q, freq_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0]   cval_q, cval_d;
  logic [CYCLE_W-1:0] ccnt_q, ccnt_d;

  logic [PHASE_W:0]   sum_c;
  logic               carry_c;
  logic [CYCLE_W-1:0] cnt_inc_c;

  // Extra top bit of the sum is the carry out of the accumulator MSB
  assign sum_c     = {1'b0, acc_q} + {1'b0, freq_q};
  assign carry_c   = enable & ~phase_wr & sum_c[PHASE_W];
  assign cnt_inc_c = cnt_q + CYCLE_W'(carry_c);

  // Next-state logic; tic latches see this cycle's accumulator update and carry
  always_comb begin
    acc_d  = acc_q;
    freq_d = freq_q;
    cnt_d  = cnt_inc_c;
    cval_d = cval_q;
    ccnt_d = ccnt_q;

    if (phase_wr) begin
      acc_d = phase_in;
    end else if (enable) begin
      acc_d = sum_c[PHASE_W-1:0];
    end

    if (f_control_wr) begin
      freq_d = f_control;
    end

    if (tic) begin
      cval_d = acc_d[PHASE_W-1 -: VAL_W];
      ccnt_d = cnt_inc_c;
      cnt_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      freq_q <= '0;
      cnt_q  <= '0;
      cval_q <= '0;
      ccnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      freq_q <= freq_d;
      cnt_q  <= cnt_d;
      cval_q <= cval_d;
      ccnt_q <= ccnt_d;
    end
  end

  assign carrier_val = cval_q;
  assign cycle_count = ccnt_q;

  // Carrier samples follow the registered accumulator directly
  carrier_lut u_lut (
    .sector_i (acc_q[PHASE_W-1 -: 3]),
    .i_sign_o (i_sign),
    .i_mag_o  (i_mag),
    .q_sign_o (q_sign),
    .q_mag_o  (q_mag)
  );

endmodule

// File: tb/tb_carrier_nco_gen.sv
// Self-checking bench for carrier_nco_gen: directed vector table, corner-case
// sequences, and randomized stimulus against an arithmetic reference model.
module tb_carrier_nco_gen;

  localparam int PW = 30;
  localparam int CW = 20;
  localparam int VW = 10;
  localparam longint PMOD = 64'd1 << PW;
  localparam longint CMOD = 64'd1 << CW;

  logic          clk = 1'b0;
  logic          rstn, enable, f_control_wr, phase_wr, tic;
  logic [PW-1:0] f_control, phase_in;
  logic          i_sign, i_mag, q_sign, q_mag;
  logic [VW-1:0] carrier_val;
  logic [CW-1:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state (plain integers)
  longint m_acc, m_freq, m_cnt, m_cv, m_cc;

  // Carrier amplitude per 45-degree sector
  int I_TAB[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  int Q_TAB[8] = '{1, 2, 2, 1, -1, -2, -2, -1};

  // Expected I/Q after n enables at f=2^27, for n = 1..8
  int I_SWEEP[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int Q_SWEEP[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  typedef struct {
    logic          en;
    logic          fwr;
    logic [PW-1:0] f;
    logic          t;
    int            exp_i;
    int            exp_q;
    longint        exp_cv;
    longint        exp_cc;
  } vec_t;

  vec_t vecs[31];

  carrier_nco_gen dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .f_control_wr (f_control_wr),
    .f_control    (f_control),
    .phase_wr     (phase_wr),
    .phase_in     (phase_in),
    .tic          (tic),
    .i_sign       (i_sign),
    .i_mag        (i_mag),
    .q_sign       (q_sign),
    .q_mag        (q_mag),
    .carrier_val  (carrier_val),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic longint sm(input int v);
    logic [1:0] r;
    r = {(v > 0) ? 1'b1 : 1'b0, (v == 2 || v == -2) ? 1'b1 : 1'b0};
    return longint'(r);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int s;
    s = int'(m_acc >> (PW - 3));
    chk({tag, " I"}, longint'({i_sign, i_mag}), sm(I_TAB[s]));
    chk({tag, " Q"}, longint'({q_sign, q_mag}), sm(Q_TAB[s]));
    chk({tag, " carrier_val"}, longint'(carrier_val), m_cv);
    chk({tag, " cycle_count"}, longint'(cycle_count), m_cc);
  endtask

  // Drive one clock of stimulus, advance the model, check after the edge
  task automatic step(input logic r, input logic en, input logic fwr,
                      input logic [PW-1:0] f, input logic pwr,
                      input logic [PW-1:0] pin, input logic t,
                      input string tag);
    longint nacc, s;
    longint carry;
    rstn = r; enable = en; f_control_wr = fwr; f_control = f;
    phase_wr = pwr; phase_in = pin; tic = t;
    if (!r) begin
      m_acc = 0; m_freq = 0; m_cnt = 0; m_cv = 0; m_cc = 0;
    end else begin
      carry = 0;
      nacc  = m_acc;
      if (pwr) begin
        nacc = longint'(pin);
      end else if (en) begin
        s     = m_acc + m_freq;
        carry = (s >= PMOD) ? 1 : 0;
        nacc  = s % PMOD;
      end
      if (t) begin
        m_cv  = nacc >> (PW - VW);
        m_cc  = (m_cnt + carry) % CMOD;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + carry) % CMOD;
      end
      m_acc = nacc;
      if (fwr) m_freq = longint'(f);
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, tag);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, "reset");
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; f_control_wr = 1'b0; f_control = '0;
    phase_wr = 1'b0; phase_in = '0; tic = 1'b0;
    m_acc = 0; m_freq = 0; m_cnt = 0; m_cv = 0; m_cc = 0;

    // Sector sweep + tic latch vectors, starting from reset
    vecs[0] = '{en:1'b0, fwr:1'b1, f:30'd1 << 27, t:1'b0,
                exp_i:2, exp_q:1, exp_cv:0, exp_cc:0};
    for (int n = 1; n <= 20; n++)
      vecs[n] = '{en:1'b1, fwr:1'b0, f:'0, t:1'b0,
                  exp_i:I_SWEEP[(n-1)%8], exp_q:Q_SWEEP[(n-1)%8],
                  exp_cv:0, exp_cc:0};
    vecs[21] = '{en:1'b0, fwr:1'b0, f:'0, t:1'b1,
                 exp_i:-2, exp_q:-1, exp_cv:512, exp_cc:2};
    for (int n = 21; n <= 28; n++)
      vecs[n+1] = '{en:1'b1, fwr:1'b0, f:'0, t:1'b0,
                    exp_i:I_SWEEP[(n-1)%8], exp_q:Q_SWEEP[(n-1)%8],
                    exp_cv:512, exp_cc:2};
    vecs[30] = '{en:1'b0, fwr:1'b0, f:'0, t:1'b1,
                 exp_i:-2, exp_q:-1, exp_cv:512, exp_cc:1};

    // 1. Reset held for three clocks
    for (int k = 0; k < 3; k++) do_reset();
    chk("reset I", longint'({i_sign, i_mag}), 3);
    chk("reset Q", longint'({q_sign, q_mag}), 2);
    chk("reset carrier_val", longint'(carrier_val), 0);
    chk("reset cycle_count", longint'(cycle_count), 0);

    // 2/3. Vector table
    for (int v = 0; v < 31; v++) begin
      step(1'b1, vecs[v].en, vecs[v].fwr, vecs[v].f, 1'b0, '0, vecs[v].t,
           $sformatf("vec%0d", v));
      chk($sformatf("vec%0d I", v), longint'({i_sign, i_mag}), sm(vecs[v].exp_i));
      chk($sformatf("vec%0d Q", v), longint'({q_sign, q_mag}), sm(vecs[v].exp_q));
      chk($sformatf("vec%0d carrier_val", v), longint'(carrier_val), vecs[v].exp_cv);
      chk($sformatf("vec%0d cycle_count", v), longint'(cycle_count), vecs[v].exp_cc);
    end

    // 4. Tic coincident with a carry
    do_reset();
    step(1'b1, 1'b0, 1'b1, 30'd1 << 27, 1'b0, '0, 1'b0, "t4 f");
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 30'h3800_0000, 1'b0, "t4 preset");
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, "t4 carry");
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 30'h3800_0000, 1'b0, "t4 preset2");
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, "t4 tic+carry");
    chk("t4 cycle_count", longint'(cycle_count), 2);
    chk("t4 carrier_val", longint'(carrier_val), 0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, "t4 tic2");
    chk("t4 cleared", longint'(cycle_count), 0);

    // 5. Write races
    do_reset();
    step(1'b1, 1'b0, 1'b1, 30'd1 << 27, 1'b0, '0, 1'b0, "t5 f");
    step(1'b1, 1'b1, 1'b1, 30'd1 << 28, 1'b0, '0, 1'b0, "t5 f race");
    chk("t5 old freq I", longint'({i_sign, i_mag}), sm(1));
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, "t5 new freq");
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, "t5 tic");
    chk("t5 carrier_val", longint'(carrier_val), 384);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 30'h3C00_0000, 1'b0, "t5 preset");
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, "t5 clear");
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 30'h1000_0000, 1'b0, "t5 phase race");
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, "t5 tic2");
    chk("t5 no carry", longint'(cycle_count), 0);
    chk("t5 phase val", longint'(carrier_val), 256);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 30'h2AB0_0000, 1'b1, "t5 tic+phase");
    chk("t5 tic+phase val", longint'(carrier_val), 683);

    // 6. Hold with enable low, then reset mid-sweep with strobes pending
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, "t6 run");
    for (int k = 0; k < 10; k++) idle("t6 hold");
    step(1'b0, 1'b1, 1'b1, 30'd12345, 1'b1, 30'h2000_0000, 1'b1, "t6 reset");
    chk("t6 reset I", longint'({i_sign, i_mag}), 3);
    chk("t6 reset Q", longint'({q_sign, q_mag}), 2);
    chk("t6 reset carrier_val", longint'(carrier_val), 0);
    chk("t6 reset cycle_count", longint'(cycle_count), 0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, "t6 after");
    chk("t6 freq discarded", longint'({i_sign, i_mag}), 3);

    // Randomized stimulus against the model
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           PW'($urandom()),
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           PW'($urandom()),
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
